// File: rtl/kp_voice_bank.sv
// Time-multiplexed Karplus-Strong voice bank: VOICES plucked strings share one delay
// RAM and one averaging/decay datapath; voice outputs are summed into a saturated mix.
module kp_voice_bank #(
  parameter int  DATA_W  = 24,
  parameter int  ADDR_W  = 11,
  parameter int  VOICES  = 4,
  parameter int  NOISE_W = 16,
  parameter int  VEL_W   = 7,
  parameter int  GAIN_W  = 12,
  localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                      a_clk,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic                      trig,
  input  logic [VW-1:0]             trig_voice,
  input  logic [ADDR_W-1:0]         trig_length,
  input  logic [VEL_W-1:0]          trig_velocity,
  input  logic signed [NOISE_W-1:0] dnoise,
  input  logic [GAIN_W-1:0]         decay,
  output logic [VOICES-1:0]         voice_active,
  output logic signed [DATA_W-1:0]  qout,
  output logic                      out_valid,
  output logic                      overrun
);

  localparam int ACC_W     = DATA_W + VW;
  localparam int SUM_W     = DATA_W + 1;
  localparam int PROD_W    = SUM_W + GAIN_W + 1;
  localparam int EXC_W     = NOISE_W + VEL_W + 1;
  localparam int RAM_AW    = VW + ADDR_W;
  localparam int RAM_DEPTH = VOICES * (2 ** ADDR_W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXCITE = 2'd1;
  localparam logic [1:0] ST_RING   = 2'd2;

  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_DATA = 2'd1;
  localparam logic [1:0] PH_CALC = 2'd2;
  localparam logic [1:0] PH_WB   = 2'd3;

  // Per-voice string state
  logic [1:0]               state_q    [VOICES];
  logic [1:0]               state_d    [VOICES];
  logic [ADDR_W-1:0]        ptr_q      [VOICES];
  logic [ADDR_W-1:0]        ptr_d      [VOICES];
  logic [ADDR_W-1:0]        len_q      [VOICES];
  logic [ADDR_W-1:0]        len_d      [VOICES];
  logic [ADDR_W-1:0]        cnt_q      [VOICES];
  logic [ADDR_W-1:0]        cnt_d      [VOICES];
  logic [VEL_W-1:0]         vel_q      [VOICES];
  logic [VEL_W-1:0]         vel_d      [VOICES];
  logic signed [DATA_W-1:0] prev_q     [VOICES];
  logic signed [DATA_W-1:0] prev_d     [VOICES];
  logic [VOICES-1:0]        pend_q, pend_d;
  logic [ADDR_W-1:0]        pend_len_q [VOICES];
  logic [ADDR_W-1:0]        pend_len_d [VOICES];
  logic [VEL_W-1:0]         pend_vel_q [VOICES];
  logic [VEL_W-1:0]         pend_vel_d [VOICES];

  // Frame sequencer and shared datapath
  logic                     busy_q, busy_d;
  logic [1:0]               phase_q, phase_d;
  logic [VW-1:0]            slot_q, slot_d;
  logic signed [DATA_W-1:0] vout_q, vout_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] qout_q, qout_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [DATA_W-1:0] ram_mem [RAM_DEPTH];
  logic signed [DATA_W-1:0] ram_rd_q;
  logic                     ram_re, ram_we;
  logic [RAM_AW-1:0]        slot_addr;

  logic signed [SUM_W-1:0]  avg;
  logic signed [DATA_W-1:0] ring_y, excite_x;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_fits;

  assign slot_addr = {slot_q, ptr_q[slot_q]};

  always_comb begin
    avg      = (SUM_W'(ram_rd_q) + SUM_W'(prev_q[slot_q])) >>> 1;
    ring_y   = DATA_W'((PROD_W'(avg) * PROD_W'($signed({1'b0, decay}))) >>> GAIN_W);
    excite_x = DATA_W'(EXC_W'(dnoise) * EXC_W'($signed({1'b0, vel_q[slot_q]})));
    acc_sum  = acc_q + ACC_W'(vout_q);
    // The sum fits when every bit above the output sign bit repeats the sign
    acc_fits = (acc_sum[ACC_W-1:DATA_W-1] == {(VW+1){acc_sum[ACC_W-1]}});
  end

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can infer a latch.
    busy_d      = busy_q;
    phase_d     = phase_q;
    slot_d      = slot_q;
    vout_d      = vout_q;
    cur_d       = cur_q;
    acc_d       = acc_q;
    qout_d      = qout_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    vel_d       = vel_q;
    prev_d      = prev_q;
    pend_d      = pend_q;
    pend_len_d  = pend_len_q;
    pend_vel_d  = pend_vel_q;
    ram_re      = 1'b0;
    ram_we      = 1'b0;

    if (!busy_q) begin
      if (sample_tick) begin
        busy_d  = 1'b1;
        phase_d = PH_ADDR;
        slot_d  = '0;
        acc_d   = '0;
      end
    end else begin
      if (sample_tick) overrun_d = 1'b1;
      phase_d = phase_q + 2'd1;
      case (phase_q)
        PH_ADDR: begin
          ram_re = 1'b1;
          // A pending note takes effect before this slot's sample is produced
          if (pend_q[slot_q]) begin
            pend_d[slot_q] = 1'b0;
            if (pend_vel_q[slot_q] == '0) begin
              state_d[slot_q] = ST_IDLE;
            end else begin
              state_d[slot_q] = ST_EXCITE;
              ptr_d[slot_q]   = '0;
              cnt_d[slot_q]   = '0;
              len_d[slot_q]   = pend_len_q[slot_q];
              vel_d[slot_q]   = pend_vel_q[slot_q];
            end
          end
        end
        PH_DATA: ;
        PH_CALC: begin
          cur_d = ram_rd_q;
          case (state_q[slot_q])
            ST_EXCITE: vout_d = excite_x;
            ST_RING:   vout_d = ring_y;
            default:   vout_d = '0;
          endcase
        end
        PH_WB: begin
          ram_we = (state_q[slot_q] == ST_EXCITE) || (state_q[slot_q] == ST_RING);
          if (state_q[slot_q] == ST_EXCITE) begin
            ptr_d[slot_q] = ptr_q[slot_q] + ADDR_W'(1);
            cnt_d[slot_q] = cnt_q[slot_q] + ADDR_W'(1);
            if (cnt_q[slot_q] == len_q[slot_q] - ADDR_W'(1)) begin
              state_d[slot_q] = ST_RING;
              ptr_d[slot_q]   = '0;
              prev_d[slot_q]  = '0;
            end
          end else if (state_q[slot_q] == ST_RING) begin
            prev_d[slot_q] = cur_q;
            ptr_d[slot_q]  = (ptr_q[slot_q] == len_q[slot_q] - ADDR_W'(1)) ?
                             '0 : ptr_q[slot_q] + ADDR_W'(1);
          end
          if (slot_q == VW'(VOICES - 1)) begin
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            qout_d      = acc_fits ? acc_sum[DATA_W-1:0] :
                          {acc_sum[ACC_W-1], {(DATA_W-1){~acc_sum[ACC_W-1]}}};
          end else begin
            slot_d = slot_q + VW'(1);
            acc_d  = acc_sum;
          end
        end
      endcase
    end

    // Applied last so a trig coinciding with consumption is kept for next frame
    if (trig) begin
      pend_d[trig_voice]     = 1'b1;
      pend_len_d[trig_voice] = (trig_length < ADDR_W'(2)) ? ADDR_W'(2) : trig_length;
      pend_vel_d[trig_voice] = trig_velocity;
    end
  end

  // NOTE: the delay RAM has no reset; each location is written in EXCITE before RING reads it.
  always_ff @(posedge a_clk) begin
    if (ram_we) ram_mem[slot_addr] <= vout_q;
    if (ram_re) ram_rd_q <= ram_mem[slot_addr];
  end

  // NOTE: state registers use <= only; all next-state math lives in always_comb.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      phase_q     <= PH_ADDR;
      slot_q      <= '0;
      vout_q      <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      qout_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= '0;
      for (int v = 0; v < VOICES; v++) begin
        state_q[v]    <= ST_IDLE;
        ptr_q[v]      <= '0;
        len_q[v]      <= ADDR_W'(2);
        cnt_q[v]      <= '0;
        vel_q[v]      <= '0;
        prev_q[v]     <= '0;
        pend_len_q[v] <= '0;
        pend_vel_q[v] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      phase_q     <= phase_d;
      slot_q      <= slot_d;
      vout_q      <= vout_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      qout_q      <= qout_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      vel_q       <= vel_d;
      prev_q      <= prev_d;
      pend_len_q  <= pend_len_d;
      pend_vel_q  <= pend_vel_d;
    end
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) voice_active[v] = (state_q[v] != ST_IDLE);
  end

  assign qout      = qout_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
